// File: rtl/icache_pkg.sv
// Shared geometry, FSM state and tag-entry types for the direct-mapped L1 instruction cache.
package icache_pkg;

  localparam int ADDR       = 32;
  localparam int INST       = 32;
  localparam int L1_CACHE   = 1024;
  localparam int LINE_BYTES = 16;

  localparam int LINE_WORDS = LINE_BYTES * 8 / INST;
  localparam int OFS        = $clog2(LINE_BYTES);
  localparam int IDX        = $clog2(L1_CACHE / LINE_BYTES);
  localparam int TAG        = ADDR - OFS - IDX;
  localparam int WORD_BITS  = $clog2(LINE_WORDS);
  localparam int SETS       = 1 << IDX;
  localparam int RAM_DEPTH  = L1_CACHE * 8 / INST;
  localparam int RAM_AW     = $clog2(RAM_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    MISS_REQ,
    REFILL,
    RESP
  } IcState_t;

  typedef struct packed {
    logic           valid;
    logic [TAG-1:0] tag;
  } tag_entry_t;

endpackage

// File: rtl/icache_data_ram.sv
// Instruction data store: one write port and one registered read port, read data valid the cycle after re.
// No backpressure; a read and a write to the same word in one cycle never happens in this cache.
module icache_data_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/l1_icache.sv
// Direct-mapped L1 I-cache feeding fetch: a hit returns its word one cycle after acceptance.
// Backpressure: ic_ready drops on a detected miss, during refill/response and while an invalidate is applied.
module l1_icache
  import icache_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            ic_req,
  input  logic [ADDR-1:0] ic_addr,
  output logic            ic_ready,
  output logic            ic_valid,
  output logic [INST-1:0] ic_inst,
  input  logic            ic_flush,
  input  logic            ic_inv,
  output logic            mem_req,
  output logic [ADDR-1:0] mem_addr,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [INST-1:0] mem_rdata
);

  localparam logic [WORD_BITS-1:0] LAST_BEAT = WORD_BITS'(LINE_WORDS - 1);

  IcState_t             state_q, state_d;
  tag_entry_t           tag_q [SETS];
  logic                 pend_vld_q;
  logic [TAG-1:0]       pend_tag_q;
  logic [IDX-1:0]       pend_idx_q;
  logic [WORD_BITS-1:0] pend_word_q;
  logic [WORD_BITS-1:0] beat_q;
  logic                 kill_q;
  logic                 inv_pend_q;
  logic [INST-1:0]      resp_q;
  logic [INST-1:0]      ram_rdata;

  logic       accept;
  logic       hit_raw;
  logic       lookup_hit;
  logic       lookup_miss;
  logic       inv_req;
  logic       inv_apply;
  logic       refill_last;
  logic       beat_we;
  tag_entry_t cur_entry;
  logic       unused_addr_bits;

  assign unused_addr_bits = ^ic_addr[1:0];

  assign cur_entry   = tag_q[pend_idx_q];
  assign hit_raw     = cur_entry.valid && (cur_entry.tag == pend_tag_q);
  assign lookup_hit  = pend_vld_q && hit_raw;
  assign lookup_miss = pend_vld_q && !hit_raw;
  assign inv_req     = ic_inv || inv_pend_q;
  assign accept      = ic_req && ic_ready;
  assign mem_addr    = {pend_tag_q, pend_idx_q, {OFS{1'b0}}};
  assign ic_inst     = ic_valid ? ((state_q == RESP) ? resp_q : ram_rdata) : '0;

  always_comb begin
    state_d     = state_q;
    ic_ready    = 1'b0;
    ic_valid    = 1'b0;
    mem_req     = 1'b0;
    inv_apply   = 1'b0;
    refill_last = 1'b0;
    beat_we     = 1'b0;
    case (state_q)
      IDLE: begin
        ic_ready  = !lookup_miss && !inv_req;
        ic_valid  = lookup_hit && !ic_flush;
        inv_apply = inv_req && !lookup_miss;
        if (lookup_miss && !ic_flush) begin
          state_d = MISS_REQ;
        end
      end
      MISS_REQ: begin
        mem_req = 1'b1;
        if (mem_gnt) begin
          state_d = REFILL;
        end else if (ic_flush) begin
          state_d = IDLE;
        end
      end
      REFILL: begin
        beat_we = mem_rvalid;
        // Memory cannot be cancelled, so a killed miss still fills the line.
        if (mem_rvalid && (beat_q == LAST_BEAT)) begin
          refill_last = 1'b1;
          state_d     = (kill_q || ic_flush) ? IDLE : RESP;
        end
      end
      RESP: begin
        ic_valid = !ic_flush;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      pend_vld_q  <= 1'b0;
      pend_tag_q  <= '0;
      pend_idx_q  <= '0;
      pend_word_q <= '0;
      beat_q      <= '0;
      kill_q      <= 1'b0;
      inv_pend_q  <= 1'b0;
      resp_q      <= '0;
      for (int i = 0; i < SETS; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      pend_vld_q <= accept;
      if (accept) begin
        pend_tag_q  <= ic_addr[ADDR-1:OFS+IDX];
        pend_idx_q  <= ic_addr[OFS+IDX-1:OFS];
        pend_word_q <= ic_addr[OFS-1:2];
      end

      if (inv_apply) begin
        inv_pend_q <= 1'b0;
      end else if (ic_inv) begin
        inv_pend_q <= 1'b1;
      end

      if (inv_apply) begin
        for (int i = 0; i < SETS; i++) begin
          tag_q[i].valid <= 1'b0;
        end
      end else if (refill_last) begin
        tag_q[pend_idx_q] <= '{valid: 1'b1, tag: pend_tag_q};
      end

      if (state_q == MISS_REQ) begin
        beat_q <= '0;
      end else if (beat_we) begin
        beat_q <= beat_q + WORD_BITS'(1);
      end

      if (beat_we && (beat_q == pend_word_q)) begin
        resp_q <= mem_rdata;
      end

      // A flush racing the grant still kills the response of the refill it starts.
      if (state_q == MISS_REQ) begin
        kill_q <= ic_flush && mem_gnt;
      end else if (refill_last) begin
        kill_q <= 1'b0;
      end else if ((state_q == REFILL) && ic_flush) begin
        kill_q <= 1'b1;
      end
    end
  end

  icache_data_ram #(
    .WIDTH(INST),
    .DEPTH(RAM_DEPTH),
    .AW   (RAM_AW)
  ) u_data_ram (
    .clk  (clk),
    .we   (beat_we),
    .waddr({pend_idx_q, beat_q}),
    .wdata(mem_rdata),
    .re   (accept),
    .raddr(ic_addr[OFS+IDX-1:2]),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_l1_icache.sv
// Directed plus randomized bench for l1_icache against a line-residency model and a backing-memory function.
module tb_l1_icache;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ic_req = 1'b0;
  logic [31:0] ic_addr = '0;
  logic        ic_ready;
  logic        ic_valid;
  logic [31:0] ic_inst;
  logic        ic_flush = 1'b0;
  logic        ic_inv = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  int tests = 0;
  int fails = 0;

  bit          present [64];
  logic [31:0] line_of [64];

  always #5 clk = ~clk;

  l1_icache dut (
    .clk       (clk),
    .reset     (reset),
    .ic_req    (ic_req),
    .ic_addr   (ic_addr),
    .ic_ready  (ic_ready),
    .ic_valid  (ic_valid),
    .ic_inst   (ic_inst),
    .ic_flush  (ic_flush),
    .ic_inv    (ic_inv),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_gnt   (mem_gnt),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = a & 32'hFFFF_FFFC;
    return (w * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic int set_of(input logic [31:0] a);
    return int'((a >> 4) % 64);
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return present[set_of(a)] && (line_of[set_of(a)] == (a & 32'hFFFF_FFF0));
  endfunction

  task automatic model_fill(input logic [31:0] a);
    present[set_of(a)] = 1'b1;
    line_of[set_of(a)] = a & 32'hFFFF_FFF0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) present[i] = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at the start of a cycle (just after a falling edge); returns at the start of a later cycle.
  task automatic fetch(input logic [31:0] a, input bit fl_req, input int fl_beat);
    bit          exp_hit;
    bit          killed;
    int          d;
    int          b;
    logic [31:0] line;
    line = a & 32'hFFFF_FFF0;
    ic_req = 1'b1;
    ic_addr = a;
    #1;
    chk("accept_rdy", 32'(ic_ready), 1);
    @(negedge clk);
    ic_req = 1'b0;
    exp_hit = model_hit(a);
    #1;
    chk("lookup_vld", 32'(ic_valid), 32'(exp_hit));
    if (exp_hit) begin
      chk("hit_inst", ic_inst, mem_word(a));
      chk("hit_noreq", 32'(mem_req), 0);
      @(negedge clk);
      return;
    end
    chk("miss_rdy", 32'(ic_ready), 0);
    @(negedge clk);
    if (fl_req) begin
      #1;
      chk("req_before_flush", 32'(mem_req), 1);
      ic_flush = 1'b1;
      @(negedge clk);
      ic_flush = 1'b0;
      #1;
      chk("flushreq_drop", 32'(mem_req), 0);
      chk("flushreq_vld", 32'(ic_valid), 0);
      chk("flushreq_rdy", 32'(ic_ready), 1);
      @(negedge clk);
      return;
    end
    d = int'($urandom_range(0, 3));
    for (int i = 0; i <= d; i++) begin
      #1;
      chk("mem_req", 32'(mem_req), 1);
      chk("mem_addr", mem_addr, line);
      chk("req_rdy", 32'(ic_ready), 0);
      if (i == d) mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
    end
    b = 0;
    killed = 1'b0;
    while (b < 4) begin
      if ($urandom_range(0, 3) == 0) begin
        mem_rvalid = 1'b0;
      end else begin
        mem_rvalid = 1'b1;
        mem_rdata = mem_word(line + 32'(4 * b));
        if (b == fl_beat) begin
          ic_flush = 1'b1;
          killed = 1'b1;
        end
        b++;
      end
      #1;
      chk("refill_rdy", 32'(ic_ready), 0);
      chk("refill_vld", 32'(ic_valid), 0);
      @(negedge clk);
      mem_rvalid = 1'b0;
      ic_flush = 1'b0;
    end
    model_fill(a);
    #1;
    chk("resp_vld", 32'(ic_valid), 32'(!killed));
    chk("resp_rdy", 32'(ic_ready), 32'(killed));
    if (!killed) chk("resp_inst", ic_inst, mem_word(a));
    @(negedge clk);
  endtask

  task automatic hit_burst(input logic [31:0] base, input int n);
    logic [31:0] prev;
    prev = '0;
    for (int i = 0; i <= n; i++) begin
      ic_req = (i < n);
      ic_addr = base + 32'(4 * i);
      #1;
      if (i > 0) begin
        chk("burst_vld", 32'(ic_valid), 32'(model_hit(prev)));
        chk("burst_inst", ic_inst, mem_word(prev));
        chk("burst_noreq", 32'(mem_req), 0);
      end
      if (i < n) chk("burst_rdy", 32'(ic_ready), 1);
      prev = ic_addr;
      @(negedge clk);
    end
    ic_req = 1'b0;
  endtask

  task automatic flush_lookup(input logic [31:0] a);
    ic_req = 1'b1;
    ic_addr = a;
    #1;
    chk("fl_accept_rdy", 32'(ic_ready), 1);
    @(negedge clk);
    ic_req = 1'b0;
    ic_flush = 1'b1;
    #1;
    chk("fl_idle_vld", 32'(ic_valid), 0);
    chk("fl_idle_req", 32'(mem_req), 0);
    @(negedge clk);
    ic_flush = 1'b0;
    #1;
    chk("fl_idle_noreq", 32'(mem_req), 0);
    chk("fl_idle_rdy", 32'(ic_ready), 1);
    @(negedge clk);
  endtask

  task automatic invalidate();
    ic_inv = 1'b1;
    #1;
    chk("inv_rdy", 32'(ic_ready), 0);
    @(negedge clk);
    ic_inv = 1'b0;
    model_clear();
    #1;
    chk("post_inv_rdy", 32'(ic_ready), 1);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] a;
    int          r;
    model_clear();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_vld", 32'(ic_valid), 0);
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_inst", ic_inst, 0);
    chk("rst_rdy", 32'(ic_ready), 1);
    @(negedge clk);

    fetch(32'h0000_0104, 1'b0, -1);
    hit_burst(32'h0000_0100, 4);
    fetch(32'h0000_0500, 1'b0, -1);
    fetch(32'h0000_0100, 1'b0, -1);
    fetch(32'h0000_0208, 1'b0, 2);
    fetch(32'h0000_0208, 1'b0, -1);
    fetch(32'h0000_0604, 1'b1, -1);
    fetch(32'h0000_0604, 1'b0, -1);
    flush_lookup(32'h0000_0104);
    flush_lookup(32'h0000_0700);
    invalidate();
    fetch(32'h0000_0100, 1'b0, -1);

    for (int n = 0; n < 80; n++) begin
      a = (32'($urandom_range(0, 2)) << 10) | (32'($urandom_range(0, 3)) << 4)
        | (32'($urandom_range(0, 3)) << 2);
      r = int'($urandom_range(0, 15));
      if (r == 0) fetch(a, 1'b1, -1);
      else if (r == 1) fetch(a, 1'b0, int'($urandom_range(0, 3)));
      else if (r == 2) flush_lookup(a);
      else if (r == 3) invalidate();
      else fetch(a, 1'b0, -1);
    end

    // Reset in the middle of a refill: the line must stay invalid and late beats are ignored.
    ic_req = 1'b1;
    ic_addr = 32'h0000_0300;
    @(negedge clk);
    ic_req = 1'b0;
    @(negedge clk);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    for (int b = 0; b < 2; b++) begin
      mem_rvalid = 1'b1;
      mem_rdata = mem_word(32'h0000_0300 + 32'(4 * b));
      @(negedge clk);
    end
    mem_rvalid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    mem_rvalid = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("midrst_vld", 32'(ic_valid), 0);
    chk("midrst_req", 32'(mem_req), 0);
    chk("midrst_rdy", 32'(ic_ready), 1);
    @(negedge clk);
    mem_rvalid = 1'b0;
    fetch(32'h0000_0104, 1'b0, -1);
    fetch(32'h0000_030C, 1'b0, -1);
    fetch(32'h0000_030C, 1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/l1_icache.md
Name: l1_icache

Overview:
- Direct-mapped L1 instruction cache that directly feeds fetch_top, in place of the fixed-content instruction ROM.
- Serves one instruction per cycle on a hit.
- On a miss, refills one line from the next memory level through a simple request/beat interface.
- Supports a fetch-redirect kill (flush) and a whole-cache invalidate (fence.i).

Parameters:
ADDR, 32, fetch/memory address width in bits
INST, 32, instruction width; also the memory beat width
L1_CACHE, 1024, cache capacity in bytes
LINE_BYTES, 16, line size in bytes; LINE_WORDS = LINE_BYTES*8/INST = 4

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
ic_req  in  1  fetch presents a lookup
ic_addr  in  ADDR  fetch PC; bits [1:0] ignored
ic_ready  out  1  cache accepts ic_req this cycle
ic_valid  out  1  ic_inst valid this cycle
ic_inst  out  INST  returned instruction
ic_flush  in  1  kill any outstanding lookup/miss response
ic_inv  in  1  invalidate all lines
mem_req  out  1  line refill request, held until grant
mem_addr  out  ADDR  line-aligned refill address
mem_gnt  in  1  memory accepted mem_req
mem_rvalid  in  1  refill beat valid
mem_rdata  in  INST  refill beat, ascending word order

Behaviour:
- Address split:
  - OFS = log2(LINE_BYTES) = 4.
  - IDX = log2(L1_CACHE/LINE_BYTES) = 6.
  - word = addr[OFS-1:2], index = addr[OFS+IDX-1:OFS], tag = addr[ADDR-1:OFS+IDX] (22 bits).
- Storage:
  - Tag array and valid bits in flops.
  - Data array is a synchronous-read RAM, 1 read and 1 write port, line-index x word addressed.
- Request acceptance:
  - A request is accepted in cycle N when ic_req && ic_ready.
  - The address is registered as the pending lookup.
  - The tag compare happens in N+1.
- Hit: ic_valid=1 and ic_inst=data in N+1. Back-to-back hits give full throughput.
- Miss:
  - In N+1, ic_valid=0 and ic_ready=0 (combinational on the compare), so no new request is accepted.
  - The FSM leaves IDLE.
- FSM states: IDLE, MISS_REQ, REFILL, RESP.
  - IDLE: ic_ready = !(pending && miss) && !ic_inv. On a pending miss and no flush, go to MISS_REQ.
  - MISS_REQ:
    - mem_req=1, mem_addr = {tag,index,OFS'0}, stable until mem_gnt.
    - On mem_gnt go to REFILL with beat counter = 0.
    - If ic_flush is seen and there is no grant in the same cycle, drop the miss and go to IDLE.
  - REFILL:
    - Each mem_rvalid writes mem_rdata to data[index][beat] and increments the beat counter.
    - The beat whose number == word is captured into a response register.
    - On the last beat (counter == LINE_WORDS-1): write the tag, set valid[index], then go to RESP, or to IDLE if the kill flag is set.
    - ic_flush during REFILL sets the kill flag; the refill always completes because memory cannot be cancelled.
  - RESP: ic_valid=1 with the captured word (unless ic_flush this cycle), ic_ready=0, then go to IDLE.
- ic_flush in IDLE:
  - Suppresses ic_valid for the pending lookup and prevents a miss transition.
  - A request presented in the same cycle as ic_flush (the redirect target) is accepted if ic_ready=1.
- ic_inv:
  - Honoured only in IDLE with no pending miss; clears all valid bits at the next edge.
  - ic_ready=0 that cycle.
  - In other states it is held pending and applied on return to IDLE, before any new acceptance.
- Simultaneous request and write to the same index: cannot occur, since ic_ready=0 outside IDLE.
- Reset state:
  - State IDLE; all valid bits 0; pending 0; kill flag 0; beat counter 0.
  - ic_valid=0, mem_req=0, ic_inst=0, ic_ready=1 in the first cycle after reset.
- Reset mid-refill: abandon the refill and leave the line invalid. Beats arriving after reset are ignored because the FSM is in IDLE.
- Beat counter wraps modulo LINE_WORDS. Extra mem_rvalid outside REFILL is ignored.

Decomposition:
- Package icache_pkg: IcState_t enum (IDLE, MISS_REQ, REFILL, RESP), derived widths OFS/IDX/TAG/WORD_BITS computed from the parameters, and a typedef for the tag entry {valid, tag}.
- One sub-module: icache_data_ram (sync-read single-write RAM, INST wide, depth L1_CACHE*8/INST).

Test Plan:
- Cold miss, addr 0x0000_0104:
  - mem_req=1 with mem_addr 0x0000_0100.
  - After grant, send 4 beats A0..A3 → ic_valid=1 with A1 in the cycle after the last beat.
  - ic_ready=0 throughout the miss.
- Hits after refill: requests 0x100, 0x104, 0x108, 0x10C on consecutive cycles → ic_valid every cycle with A0..A3, no mem_req.
- Conflict: request 0x0000_0500 (same index, different tag) → miss and refill. A later request to 0x100 misses again.
- ic_flush asserted during REFILL beat 2:
  - All 4 beats are still written and the line becomes valid.
  - No ic_valid response.
  - A subsequent request to the same address hits.
- ic_flush in MISS_REQ before grant → mem_req drops the next cycle, state IDLE, no response.
- Invalidate and reset:
  - ic_inv in IDLE after fills → a following request to 0x100 misses.
  - Reset asserted mid-REFILL → state IDLE, all lines invalid, ic_valid=0.
